alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute stage of the VR16 core. It sits directly upstream of the general-purpose register file and produces the `alu_result`, `write_enable` and `select_reg` signals that the register file consumes.
- Accepts one operation at a time from the decoder over a start/busy handshake.
- Logic, add/sub and shift ops complete in one cycle. MUL is an iterative 16-cycle shift-add unit.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- MUL_CYCLES, 16, number of MUL iteration cycles; must equal WIDTH.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled at each rising edge.
- op  input  3  opcode (see Behaviour).
- dest_sel  input  2  destination register index (00=A, 01=B, 10=C, 11=D).
- operand_a  input  16  first operand, from the register-file read mux.
- operand_b  input  16  second operand.
- busy  output  1  a MUL is in progress; start is ignored while high.
- alu_result  output  16  registered result; connects to the register file's alu_result input.
- write_enable  output  1  one-cycle pulse marking a valid result.
- select_reg  output  2  registered dest_sel, aligned with write_enable.
- carry  output  1  carry/borrow/overflow flag of the last result.
- zero  output  1  high when the last alu_result is 0x0000.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; busy, write_enable, carry and zero = 0; alu_result = 0x0000; select_reg = 00; all MUL internals cleared. Asserting reset mid-MUL aborts the MUL and no write_enable is ever issued for it.
- Opcodes:
  - 000 ADD: carry = bit 16 of the 17-bit sum.
  - 001 SUB: A−B; carry = borrow (A<B unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A << B[3:0]; carry = last bit shifted out, 0 if shift amount is 0.
  - 110 SHR: logical A >> B[3:0]; carry as for SHL.
  - 111 MUL: unsigned; low 16 bits of the product; carry = 1 if the high 16 bits are nonzero.
  - For AND, OR and XOR, carry = 0.
- zero is always recomputed from the new alu_result whenever write_enable pulses.
- FSM states: IDLE, MUL, DONE.
  - IDLE: start=1 with op≠111 sampled at edge k → alu_result, flags and select_reg are updated and write_enable=1 during cycle k+1. State stays IDLE, so back-to-back starts give a result every cycle.
  - IDLE: start=1 with op=111 at edge k → operands and dest_sel are latched, iteration counter cleared, go to MUL. busy=1 in cycles k+1..k+16.
  - MUL: one shift-add iteration per edge (multiplicand << 1, multiplier >> 1, 32-bit accumulator). After iteration 16 → DONE. start is ignored and no request is queued.
  - DONE: cycle k+17, busy=0, write_enable=1, outputs updated. A start sampled at the edge ending this cycle is accepted normally, then return to IDLE.
- write_enable is 0 in every cycle not listed above. Between writes, alu_result, select_reg, carry and zero hold their last values.
- Operands are sampled only at the accepting edge, so later changes on operand_a/b do not affect an in-flight MUL.
- No combinational path from any input to any output.

Decomposition:
- Package vr16_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (3-bit);
  - state encoding ST_IDLE/ST_MUL/ST_DONE;
  - register-index constants REG_A..REG_D (2'b00..2'b11).
- One sub-module, mul_iter: the iterative shift-add multiplier. It has start, done, the 32-bit product and its own counter, with the same clk and active-low async reset.
- Single-cycle ops and the output registers stay in alu_exec.

Test Plan:
- ADD 0xFFFF + 0x0001, dest=10, start at edge k → cycle k+1: write_enable=1, alu_result=0x0000, carry=1, zero=1, select_reg=10; cycle k+2: write_enable=0.
- SUB 0x0003 − 0x0005, dest=01 → alu_result=0xFFFE, carry=1, zero=0. Then back-to-back XOR 0x00FF^0x0F0F on the next cycle → 0x0FF0 one cycle later, carry=0.
- MUL 0x0012 × 0x0034, dest=11, start at edge k → busy=1 for cycles k+1..k+16; write_enable=1 only in k+17 with alu_result=0x03A8, carry=0, select_reg=11.
- MUL 0x0100 × 0x0100 → alu_result=0x0000, carry=1, zero=1 at k+17. An ADD start pulsed at cycle k+5 is ignored: no extra write_enable and the result is unchanged.
- SHL 0x8001 by 1 → 0x0002, carry=1. SHR 0x0001 by 0x0010 (shift amount B[3:0]=0) → 0x0001, carry=0.
- Reset pulled low at cycle k+8 of a MUL → all outputs 0 immediately (asynchronously). After release, no write_enable appears, and a new ADD 0x0002+0x0003 yields 0x0005 one cycle after start.

Source files
------------

// File: rtl/vr16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vr16_pkg
//  Purpose  : Shared constants for the VR16 execute stage: opcodes, the
//             execute-stage state encoding and register-file indices.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vr16_pkg;

    // Opcodes presented by the decoder on op[2:0]
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Execute-stage state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Register-file destination indices
    localparam logic [1:0] REG_A = 2'b00;
    localparam logic [1:0] REG_B = 2'b01;
    localparam logic [1:0] REG_C = 2'b10;
    localparam logic [1:0] REG_D = 2'b11;

endpackage : vr16_pkg
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_iter
//  Purpose  : Iterative unsigned shift-add multiplier, one partial product
//             per clock, MUL_CYCLES iterations per operation.
//  Ports    : clk          - core clock, rising edge
//             reset        - asynchronous active-low reset
//             start        - load operands and begin (ignored while running)
//             multiplicand - first operand
//             multiplier   - second operand
//             done         - high in the cycle whose closing edge performs
//                            the final iteration
//             product      - accumulator value after the current iteration;
//                            the full product when done is high
//  Revision : 1.0  initial release
// ============================================================================
module mul_iter #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(MUL_CYCLES - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    // Partial product for this iteration is selected by the multiplier LSB.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Exposing the post-iteration value lets the parent capture the final
    // product on the same edge that retires the last iteration.
    assign product = w_acc_next;
    assign done    = r_busy && (r_count == c_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
            if (r_count == c_last) begin
                r_busy <= 1'b0;
            end
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end
    end

endmodule : mul_iter
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec
//  Purpose  : VR16 execute stage. Single-cycle logic/arith/shift ops and a
//             16-cycle iterative MUL, feeding the register file.
//  Ports    : clk, reset (async active-low)
//             start, op, dest_sel, operand_a, operand_b  - request from decoder
//             busy          - MUL in progress, start ignored
//             alu_result    - registered result to the register file
//             write_enable  - one-cycle pulse marking a valid result
//             select_reg    - destination index aligned with write_enable
//             carry, zero   - flags of the last result
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec
    import vr16_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [1:0]       dest_sel,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic [WIDTH-1:0] alu_result,
    output logic             write_enable,
    output logic [1:0]       select_reg,
    output logic             carry,
    output logic             zero
);

    localparam int SH_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_result;
    logic               r_we;
    logic [1:0]         r_sel;
    logic               r_carry;
    logic               r_zero;
    logic [1:0]         r_mul_dest;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_single;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;

    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;

    // Requests are taken in IDLE and DONE; a running MUL blocks everything.
    assign w_accept    = start && (r_state != ST_MUL);
    assign w_mul_start = w_accept && (op == OP_MUL);
    assign w_single    = w_accept && (op != OP_MUL);

    mul_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_iter (
        .clk          (clk),
        .reset        (reset),
        .start        (w_mul_start),
        .multiplicand (operand_a),
        .multiplier   (operand_b),
        .done         (w_mul_done),
        .product      (w_mul_product)
    );

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_shamt = operand_b[SH_W-1:0];
    assign w_sum   = {1'b0, operand_a} + {1'b0, operand_b};
    // Bit WIDTH of the extended difference is the unsigned borrow.
    assign w_diff  = {1'b0, operand_a} - {1'b0, operand_b};
    // The extra guard bit on each shift catches the last bit shifted out,
    // and naturally stays 0 for a zero shift amount.
    assign w_shl   = {1'b0, operand_a} << w_shamt;
    assign w_shr   = {operand_a, 1'b0} >> w_shamt;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_AND: w_res = operand_a & operand_b;
            OP_OR:  w_res = operand_a | operand_b;
            OP_XOR: w_res = operand_a ^ operand_b;
            OP_SHL: begin
                w_res   = w_shl[WIDTH-1:0];
                w_carry = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res   = w_shr[WIDTH:1];
                w_carry = w_shr[0];
            end
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: w_state_next = w_mul_start ? ST_MUL : ST_IDLE;
            ST_MUL:           if (w_mul_done) w_state_next = ST_DONE;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers: written on a single-cycle accept or on the edge
    // that retires the final MUL iteration; otherwise they hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result   <= '0;
            r_we       <= 1'b0;
            r_sel      <= 2'b00;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_mul_dest <= 2'b00;
        end else begin
            r_we <= 1'b0;
            if (w_mul_done) begin
                r_result <= w_mul_product[WIDTH-1:0];
                r_carry  <= |w_mul_product[2*WIDTH-1:WIDTH];
                r_zero   <= (w_mul_product[WIDTH-1:0] == '0);
                r_sel    <= r_mul_dest;
                r_we     <= 1'b1;
            end else if (w_single) begin
                r_result <= w_res;
                r_carry  <= w_carry;
                r_zero   <= (w_res == '0);
                r_sel    <= dest_sel;
                r_we     <= 1'b1;
            end
            if (w_mul_start) begin
                r_mul_dest <= dest_sel;
            end
        end
    end

    assign busy         = (r_state == ST_MUL);
    assign alu_result   = r_result;
    assign write_enable = r_we;
    assign select_reg   = r_sel;
    assign carry        = r_carry;
    assign zero         = r_zero;

endmodule : alu_exec
`default_nettype wire

// File: tb/tb_alu_exec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec
//  Purpose  : Self-checking bench for alu_exec: vector table, hand-written
//             MUL / reset sequences and randomized ops against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec;
    import vr16_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [1:0]  dest_sel = 2'b00;
    logic [15:0] operand_a = 16'h0000;
    logic [15:0] operand_b = 16'h0000;
    logic        busy;
    logic [15:0] alu_result;
    logic        write_enable;
    logic [1:0]  select_reg;
    logic        carry;
    logic        zero;

    int n_pass   = 0;
    int n_checks = 0;

    alu_exec #(
        .WIDTH      (16),
        .MUL_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .dest_sel     (dest_sel),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .alu_result   (alu_result),
        .write_enable (write_enable),
        .select_reg   (select_reg),
        .carry        (carry),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  dest;
        logic [15:0] res;
        logic        c;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input string tag, input logic [15:0] res,
                                input logic c, input logic [1:0] sel);
        check({tag, "_we"},   32'(write_enable), 32'd1);
        check({tag, "_res"},  32'(alu_result),   32'(res));
        check({tag, "_c"},    32'(carry),        32'(c));
        check({tag, "_z"},    32'(zero),         32'(res == 16'h0000));
        check({tag, "_sel"},  32'(select_reg),   32'(sel));
    endtask

    // Reference model: plain arithmetic on wide integers. Returns {carry, result}.
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] full;
        int          sh;
        logic [15:0] r;
        logic        c;
        wa   = {16'h0000, a};
        wb   = {16'h0000, b};
        sh   = int'(b[3:0]);
        r    = 16'h0000;
        c    = 1'b0;
        full = 32'h0;
        case (o)
            OP_ADD: begin full = wa + wb; r = full[15:0]; c = (full > 32'h0000FFFF); end
            OP_SUB: begin r = a - b; c = (a < b); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                full = wa * (32'd1 << sh);
                r    = full[15:0];
                c    = (sh != 0) && (((wa >> (16 - sh)) & 32'd1) != 32'd0);
            end
            OP_SHR: begin
                full = wa / (32'd1 << sh);
                r    = full[15:0];
                c    = (sh != 0) && (((wa >> (sh - 1)) & 32'd1) != 32'd0);
            end
            default: begin full = wa * wb; r = full[15:0]; c = (full > 32'h0000FFFF); end
        endcase
        return {c, r};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h0001;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // MUL with cycle-by-cycle busy/write_enable checks. inject>0 pulses an
    // ADD request in cycle k+inject, which must be ignored.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] dest, input logic [15:0] res,
                           input logic c, input int inject);
        @(negedge clk);
        start = 1'b1; op = OP_MUL; operand_a = a; operand_b = b; dest_sel = dest;
        for (int cy = 1; cy <= 16; cy++) begin
            @(negedge clk);
            operand_a = 16'($urandom);
            operand_b = 16'($urandom);
            dest_sel  = 2'($urandom_range(0, 3));
            if (cy == inject) begin
                start = 1'b1; op = OP_ADD;
            end else begin
                start = 1'b0;
            end
            check($sformatf("%s_busy%0d", tag, cy), 32'(busy), 32'd1);
            check($sformatf("%s_we%0d", tag, cy), 32'(write_enable), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy17"}, 32'(busy), 32'd0);
        expect_write({tag, "_done"}, res, c, dest);
        @(negedge clk);
        check({tag, "_we18"}, 32'(write_enable), 32'd0);
        check({tag, "_hold"}, 32'(alu_result), 32'(res));
    endtask

    initial begin
        vec_t        v;
        logic [16:0] exp;
        int          waited;

        tbl[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, REG_C, 16'h0000, 1'b1};
        tbl[1]  = '{OP_SUB, 16'h0003, 16'h0005, REG_B, 16'hFFFE, 1'b1};
        tbl[2]  = '{OP_XOR, 16'h00FF, 16'h0F0F, REG_A, 16'h0FF0, 1'b0};
        tbl[3]  = '{OP_SHL, 16'h8001, 16'h0001, REG_D, 16'h0002, 1'b1};
        tbl[4]  = '{OP_SHR, 16'h0001, 16'h0010, REG_B, 16'h0001, 1'b0};
        tbl[5]  = '{OP_AND, 16'hF0F0, 16'h0FF0, REG_C, 16'h00F0, 1'b0};
        tbl[6]  = '{OP_OR,  16'h1200, 16'h0034, REG_A, 16'h1234, 1'b0};
        tbl[7]  = '{OP_ADD, 16'h1234, 16'h1111, REG_D, 16'h2345, 1'b0};
        tbl[8]  = '{OP_SUB, 16'h0005, 16'h0005, REG_B, 16'h0000, 1'b0};
        tbl[9]  = '{OP_SHR, 16'h4001, 16'h000F, REG_C, 16'h0000, 1'b1};
        tbl[10] = '{OP_SHL, 16'h0003, 16'h000F, REG_A, 16'h8000, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we",   32'(write_enable), 32'd0);
        check("rst_res",  32'(alu_result), 32'd0);
        check("rst_sel",  32'(select_reg), 32'd0);
        check("rst_c",    32'(carry), 32'd0);
        check("rst_z",    32'(zero), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_we", 32'(write_enable), 32'd0);

        // Vector table, issued back-to-back
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                v = tbl[i-1];
                expect_write($sformatf("vec%0d", i - 1), v.res, v.c, v.dest);
            end
            v = tbl[i];
            start = 1'b1; op = v.op; operand_a = v.a; operand_b = v.b; dest_sel = v.dest;
        end
        @(negedge clk);
        start = 1'b0;
        v = tbl[NV-1];
        expect_write($sformatf("vec%0d", NV - 1), v.res, v.c, v.dest);
        @(negedge clk);
        check("vec_we_drop", 32'(write_enable), 32'd0);
        check("vec_hold",    32'(alu_result), 32'(v.res));

        // Multi-cycle MUL sequences
        run_mul("mul1", 16'h0012, 16'h0034, REG_D, 16'h03A8, 1'b0, 0);
        run_mul("mul2", 16'h0100, 16'h0100, REG_B, 16'h0000, 1'b1, 5);

        // Leave nonzero outputs in place before aborting a MUL with reset
        @(negedge clk);
        start = 1'b1; op = OP_SHL; operand_a = 16'h0003; operand_b = 16'h000F; dest_sel = REG_C;
        @(negedge clk);
        start = 1'b0;
        expect_write("pre_rst", 16'h8000, 1'b1, REG_C);
        start = 1'b1; op = OP_MUL; operand_a = 16'h0012; operand_b = 16'h0034; dest_sel = REG_D;
        for (int cy = 1; cy <= 8; cy++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we",   32'(write_enable), 32'd0);
        check("abort_res",  32'(alu_result), 32'd0);
        check("abort_sel",  32'(select_reg), 32'd0);
        check("abort_c",    32'(carry), 32'd0);
        check("abort_z",    32'(zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int cy = 0; cy < 20; cy++) begin
            @(negedge clk);
            check($sformatf("abort_no_we%0d", cy), 32'(write_enable), 32'd0);
        end
        start = 1'b1; op = OP_ADD; operand_a = 16'h0002; operand_b = 16'h0003; dest_sel = REG_A;
        @(negedge clk);
        start = 1'b0;
        expect_write("post_rst_add", 16'h0005, 1'b0, REG_A);

        // Randomized ops against the model; each new request is issued in
        // the result cycle of the previous one (back-to-back / DONE accept).
        for (int i = 0; i < 300; i++) begin
            v.op   = 3'($urandom_range(0, 7));
            v.a    = pick();
            v.b    = pick();
            v.dest = 2'($urandom_range(0, 3));
            exp    = model(v.op, v.a, v.b);
            start = 1'b1; op = v.op; operand_a = v.a; operand_b = v.b; dest_sel = v.dest;
            @(negedge clk);
            start  = 1'b0;
            waited = 0;
            while (!write_enable && waited < 20) begin
                operand_a = 16'($urandom);
                operand_b = 16'($urandom);
                op        = 3'($urandom_range(0, 7));
                dest_sel  = 2'($urandom_range(0, 3));
                start     = busy ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                waited++;
            end
            start = 1'b0;
            check($sformatf("rnd%0d_lat", i), 32'(waited), (v.op == OP_MUL) ? 32'd16 : 32'd0);
            expect_write($sformatf("rnd%0d", i), exp[15:0], exp[16], v.dest);
        end
        @(negedge clk);
        check("rnd_we_drop", 32'(write_enable), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_exec
`default_nettype wire
